// File: rtl/pdiv_pkg.sv
// Shared types and constants for the streaming 4-bit divider.
package pdiv_pkg;
  localparam int DATA_W = 4;
  localparam logic [DATA_W-1:0] DZ_QUOTIENT = 4'hF;

  typedef struct packed {
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    logic              dz;
  } pdiv_result_t;
endpackage

// File: rtl/pdiv.sv
// Combinational 4-bit restoring divider; quotient/remainder are meaningless when b_i is 0.
module pdiv
  import pdiv_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] q_o,
  output logic [DATA_W-1:0] r_o
);
  logic [DATA_W:0]   rem;
  logic [DATA_W-1:0] quo;

  always_comb begin
    rem = '0;
    quo = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      rem = {rem[DATA_W-1:0], a_i[i]};
      if (rem >= {1'b0, b_i}) begin
        rem    = rem - {1'b0, b_i};
        quo[i] = 1'b1;
      end
    end
    q_o = quo;
    r_o = rem[DATA_W-1:0];
  end
endmodule

// File: rtl/pdiv_result_fifo.sv
// Result FIFO: power-of-2 depth, naturally wrapping pointers, count one bit wider than pointers.
module pdiv_result_fifo
  import pdiv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  pdiv_result_t                  data_i,
  input  logic                          pop_i,
  output pdiv_result_t                  head_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  pdiv_result_t  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the top gates the head to zero while empty.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/pdiv_stream.sv
// Streaming wrapper: operand register -> pdiv with divide-by-zero substitution -> result FIFO.
module pdiv_stream
  import pdiv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_q,
  output logic [DATA_W-1:0] out_r,
  output logic              out_dz,
  output logic [CNT_W-1:0]  op_count,
  output logic [CNT_W-1:0]  dz_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d, dz_count_q, dz_count_d;
  logic [DATA_W-1:0] div_q, div_r;
  pdiv_result_t      s1_result, head;
  logic [CW-1:0]     fifo_count;
  logic              accept, push, pop;

  // Both ports are valid/ready: a beat moves on any edge where valid && ready;
  // valid never waits on ready, and in_ready is a function of state and out_ready only.
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = s1_valid_q && ((fifo_count < DEPTH_C) || pop);
  assign in_ready  = !s1_valid_q || push;
  assign accept    = in_valid && in_ready;

  pdiv u_pdiv (
    .a_i (a_q),
    .b_i (b_q),
    .q_o (div_q),
    .r_o (div_r)
  );

  always_comb begin
    s1_result = '{q: div_q, r: div_r, dz: 1'b0};
    if (b_q == '0) s1_result = '{q: DZ_QUOTIENT, r: a_q, dz: 1'b1};
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_count_d = op_count_q;
    dz_count_d = dz_count_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      a_d        = in_a;
      b_d        = in_b;
    end else if (push) begin
      s1_valid_d = 1'b0;
    end
    if (push && (op_count_q != '1)) op_count_d = op_count_q + CNT_W'(1);
    if (push && s1_result.dz && (dz_count_q != '1)) dz_count_d = dz_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_count_q <= '0;
      dz_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_count_q <= op_count_d;
      dz_count_q <= dz_count_d;
    end
  end

  pdiv_result_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (s1_result),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count)
  );

  assign out_q    = out_valid ? head.q  : '0;
  assign out_r    = out_valid ? head.r  : '0;
  assign out_dz   = out_valid ? head.dz : 1'b0;
  assign op_count = op_count_q;
  assign dz_count = dz_count_q;
endmodule

// File: tb/tb_pdiv_stream.sv
// Scoreboard bench for pdiv_stream: stimulus pushes arithmetic expectations, a negedge monitor pops and compares.
module tb_pdiv_stream;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_q, out_r;
  logic       out_dz;
  logic [7:0] op_count, dz_count;

  logic [8:0] exp_q[$];
  int         acc_q[$];
  int         cycle = 0;
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         lat_left = 0;
  int         n_ops = 0;
  int         n_dz = 0;
  bit         rand_ready = 1'b0;

  pdiv_stream #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_dz    (out_dz),
    .op_count  (op_count),
    .dz_count  (dz_count)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] model(input int a, input int b);
    if (b == 0) return {4'hF, 4'(a), 1'b1};
    return {4'(a / b), 4'(a % b), 1'b0};
  endfunction

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_pair(input int a, input int b);
    exp_q.push_back(model(a, b));
    acc_q.push_back(cycle);
    n_ops++;
    if (b == 0) n_dz++;
  endtask

  // Driver tasks: entered and left at posedge+1
  task automatic send(input int a, input int b);
    bit ok = 1'b0;
    in_a = 4'(a);
    in_b = 4'(b);
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        expect_pair(a, b);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    check("send_accepted", ok, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    rand_ready = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_op_count"}, op_count, sat(n_ops));
    check({tag, "_dz_count"}, dz_count, sat(n_dz));
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    logic [8:0] e;
    int         ac;
    if (rst_n) begin
      if (out_valid && exp_q.size() == 0) begin
        check("unexpected_out_valid", out_valid, 0);
      end else if (out_valid && out_ready) begin
        e  = exp_q.pop_front();
        ac = acc_q.pop_front();
        check("result_qrdz", {out_q, out_r, out_dz}, e);
        if (lat_left > 0) begin
          check("first_latency", cycle - ac, 2);
          lat_left--;
        end
      end
    end
  end

  initial begin
    int acc;
    int k;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_qrdz", {out_q, out_r, out_dz}, 0);
    check_counters("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed back-to-back with latency check on the first
    out_ready = 1'b1;
    lat_left = 1;
    send(6, 2);
    send(5, 2);
    send(2, 5);
    drain();
    check_counters("directed");

    send(10, 0);
    drain();
    check_counters("div_zero");

    // Random traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, 15), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15));
      idle($urandom_range(0, 2));
    end
    drain();
    check_counters("random");

    // Fill: 4 in FIFO + 1 in operand stage, then a one-cycle ready pulse
    out_ready = 1'b0;
    acc = 0;
    k = 1;
    in_a = 4'(k);
    in_b = 4'd3;
    in_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (in_ready) begin
        expect_pair(k, 3);
        acc++;
        k++;
      end
      @(posedge clk);
      #1;
      in_a = 4'(k);
    end
    check("accepts_until_full", acc, 5);
    @(negedge clk);
    check("in_ready_when_full", in_ready, 0);
    check("out_valid_when_full", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_follows_out_ready", in_ready, 1);
    if (in_ready) begin
      expect_pair(k, 3);
      acc++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("in_ready_refull", in_ready, 0);
      check("out_valid_refull", out_valid, 1);
    end
    check("accepts_total", acc, 6);
    @(posedge clk);
    #1;
    drain();
    check_counters("backpressure");

    // Saturation with divide-by-zero pairs
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) send($urandom_range(0, 15), 0);
    drain();
    check_counters("saturate");

    // Reset with 2 results buffered and 1 operand pending
    out_ready = 1'b0;
    send(7, 2);
    send(9, 4);
    send(3, 1);
    check("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    n_ops = 0;
    n_dz = 0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_qrdz", {out_q, out_r, out_dz}, 0);
    check_counters("mid_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(6);
    send(13, 4);
    drain();
    check_counters("post_reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
